hazard_scoreboard: RTL

Parametrised hazard and forwarding controller for the pipelined core. It tracks the destination of every in-flight instruction between EX and write-back in an internal scoreboard shift register. From that state it produces operand forwarding selects, load-use stalls, a branch flush, and condition-flag forwarding for the ID stage. It sits beside the ID stage and drives the ID operand muxes, the PC/IF-ID enables and the ID/EX bubble insert.

---
 rtl/hazard_scoreboard_if.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Purpose: ID-stage <-> hazard/forwarding controller bundle.
//   master : ID stage (drives decoded instruction, consumes controls)
//   slave  : hazard_scoreboard
// Signals:
//   id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd, id_regwrite,
//   id_is_load, id_setflag, id_uses_flags, br_taken   (ID -> scoreboard)
//   fwd_a, fwd_b, flag_fwd, stall, flush_ifid, stall_cnt (scoreboard -> ID)
interface hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rm;
    logic                  id_rn_used;
    logic                  id_rm_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_is_load;
    logic                  id_setflag;
    logic                  id_uses_flags;
    logic                  br_taken;

    logic [SEL_W-1:0]      fwd_a;
    logic [SEL_W-1:0]      fwd_b;
    logic                  flag_fwd;
    logic                  stall;
    logic                  flush_ifid;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd,
               id_regwrite, id_is_load, id_setflag, id_uses_flags, br_taken,
        input  fwd_a, fwd_b, flag_fwd, stall, flush_ifid, stall_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd,
               id_regwrite, id_is_load, id_setflag, id_uses_flags, br_taken,
        output fwd_a, fwd_b, flag_fwd, stall, flush_ifid, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose: hazard and forwarding controller beside the ID stage. Tracks the
// destination of every in-flight instruction (stages 1..DEPTH after ID) in a
// shift-register scoreboard and derives operand forwarding selects, load-use
// stalls, branch flush and condition-flag forwarding.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    hazard_scoreboard_if.slave (ID instruction in, controls out)
// Configuration macro: HAZARD_FLAG_FWD_EN
//   defined   -> flag dependency on stage 1 is resolved by flag_fwd
//   undefined -> flag_fwd tied low, flag dependency stalls one cycle instead
// DEPTH is legal in 2..4.
module hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ZERO_REG   = 31,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned SEL_W      = $clog2(DEPTH + 1),
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   bus
);

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  is_load;
        logic                  setflag;
    } entry_t;

    // sb_q[k] describes the instruction in stage k+1
    entry_t           sb_q [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q;

    logic [SEL_W-1:0] fwd_a_c;
    logic [SEL_W-1:0] fwd_b_c;
    logic             load_use_c;
    logic             flag_dep_c;
    logic             stall_c;
    logic             flag_fwd_c;
    logic             flush_c;

    // A source depends on an entry only if it is really read and not the zero register
    function automatic logic src_hit(input entry_t e,
                                     input logic [REG_ADDR_W-1:0] s,
                                     input logic used);
        return e.valid && e.regwrite && (e.rd == s) && (s != ZERO_IDX) && used;
    endfunction

    // Forwarding selects: scan oldest to youngest so the youngest writer wins
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (src_hit(sb_q[k], bus.id_rn, bus.id_rn_used)) fwd_a_c = SEL_W'(k + 1);
            if (src_hit(sb_q[k], bus.id_rm, bus.id_rm_used)) fwd_b_c = SEL_W'(k + 1);
        end
    end

    // Load-use, flag dependency, stall and flush
    always_comb begin
        load_use_c = bus.id_valid && sb_q[0].is_load &&
                     (src_hit(sb_q[0], bus.id_rn, bus.id_rn_used) ||
                      src_hit(sb_q[0], bus.id_rm, bus.id_rm_used));
        flag_dep_c = bus.id_valid && bus.id_uses_flags &&
                     sb_q[0].valid && sb_q[0].setflag;
`ifdef HAZARD_FLAG_FWD_EN
        stall_c    = load_use_c;
        flag_fwd_c = flag_dep_c;
`else
        // Without flag forwarding, wait one cycle for the flag register update
        stall_c    = load_use_c || flag_dep_c;
        flag_fwd_c = 1'b0;
`endif
        flush_c    = bus.id_valid && bus.br_taken && !stall_c;
    end

    // Scoreboard shift and saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) sb_q[k] <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (bus.id_valid && !stall_c) begin
                sb_q[0] <= '{valid:    1'b1,
                             rd:       bus.id_rd,
                             regwrite: bus.id_regwrite,
                             is_load:  bus.id_is_load,
                             setflag:  bus.id_setflag};
            end else begin
                sb_q[0] <= '0;
            end
            for (int k = 1; k < int'(DEPTH); k++) sb_q[k] <= sb_q[k-1];
            if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Combinational controls are forced low while reset is asserted
    assign bus.fwd_a      = reset ? '0   : fwd_a_c;
    assign bus.fwd_b      = reset ? '0   : fwd_b_c;
    assign bus.flag_fwd   = reset ? 1'b0 : flag_fwd_c;
    assign bus.stall      = reset ? 1'b0 : stall_c;
    assign bus.flush_ifid = reset ? 1'b0 : flush_c;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule
